// File: rtl/i2c_slave.sv
// I2C target endpoint with a fixed 7-bit address. SCL/SDA are oversampled on clk.
// There is no clock stretching. Write bytes go out on rx_data, and read bytes are fetched via rd_req/tx_data.
module i2c_slave #(
    parameter logic [6:0] I2C_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rd_req,
    input  logic [7:0] tx_data,
    output logic       busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] WR_DATA  = 3'd3;
    localparam logic [2:0] WR_ACK   = 3'd4;
    localparam logic [2:0] RD_DATA  = 3'd5;
    localparam logic [2:0] RD_ACK   = 3'd6;
    localparam logic [2:0] IGNORE   = 3'd7;

    // [1:0] is the two-stage synchroniser, and [2] is the history stage used for edge detection.
    logic [2:0] scl_sync;
    logic [2:0] sda_sync;

    // NOTE: the synchroniser is deliberately not reset. If it were forced to 1 while SDA is held low,
    // it would fake an SDA fall with SCL high, which would be decoded as a START.
    always_ff @(posedge clk) begin
        scl_sync <= {scl_sync[1:0], scl_in};
        sda_sync <= {sda_sync[1:0], sda_in};
    end

    logic scl, scl_d, sda, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl       = scl_sync[1];
    assign scl_d     = scl_sync[2];
    assign sda       = sda_sync[1];
    assign sda_d     = sda_sync[2];
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start_det = scl & scl_d & sda_d & ~sda;
    assign stop_det  = scl & scl_d & ~sda_d & sda;

    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] tx_shift;
    logic [7:0] next_byte;
    logic       rw;
    logic       rx_pend;
    logic       tx_load;

    assign next_byte = {shift_in[6:0], sda};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shift_in <= 8'h00;
            tx_shift <= 8'h00;
            rw       <= 1'b0;
            rx_pend  <= 1'b0;
            tx_load  <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rd_req   <= 1'b0;
            rx_valid <= rx_pend;
            rx_pend  <= 1'b0;
            tx_load  <= rd_req;
            if (tx_load)
                tx_shift <= tx_data;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift_in <= next_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (next_byte[7:1] == I2C_ADDR) begin
                                state  <= ADDR_ACK;
                                busy   <= 1'b1;
                                rw     <= next_byte[0];
                                rd_req <= next_byte[0];
                            end else begin
                                state <= IGNORE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end

                    // sda_oe doubles as the phase flag: the first fall drives the ACK, and the second fall ends it.
                    ADDR_ACK, WR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (state == WR_ACK || !rw) begin
                            sda_oe <= 1'b0;
                            state  <= WR_DATA;
                        end else begin
                            sda_oe   <= ~tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            bit_cnt  <= 4'd1;
                            state    <= RD_DATA;
                        end
                    end

                    WR_DATA: if (scl_rise) begin
                        shift_in <= next_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            rx_data <= next_byte;
                            rx_pend <= 1'b1;
                            state   <= WR_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end

                    RD_DATA: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= RD_ACK;
                        end else begin
                            sda_oe   <= ~tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end

                    RD_ACK: if (scl_rise) begin
                        if (!sda) begin
                            rd_req <= 1'b1;
                            state  <= RD_DATA;
                        end else begin
                            busy  <= 1'b0;
                            state <= IGNORE;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bit-banged I2C controller, a pulse monitor,
// table-driven and random transactions against a transaction-level expectation.
module tb_i2c_slave;

    localparam int Q = 5;   // clk cycles per quarter SCL period (SCL = 20 clk)

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_req;
    logic [7:0] tx_data = 8'h00;
    logic       busy;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave #(.I2C_ADDR(7'h42)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rd_req   (rd_req),
        .tx_data  (tx_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Monitor state
    int         rx_cnt = 0;
    int         rd_cnt = 0;
    int         oe_cycles = 0;
    int         proto_err = 0;
    logic [7:0] rx_log   [64];
    logic [7:0] tx_table [256];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 64] = rx_data;
            rx_cnt++;
        end
        if (rd_req) begin
            tx_data = tx_table[rd_cnt % 256];
            rd_cnt++;
        end
        if (sda_oe)
            oe_cycles++;
        if (rx_valid && rd_req)
            proto_err++;
        if ((rx_valid || rd_req) && !busy)
            proto_err++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START (also serves as repeated START when SCL is low)
    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_line; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack_line);
        for (int i = 7; i >= 0; i--)
            write_bit(v[i]);
        read_bit(ack_line);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic b;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            v = {v[6:0], b};
        end
        write_bit(nack);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        check("reset_sda_oe", sda_oe, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
    endtask

    // One complete transaction.
    // For writes, d holds the bytes sent. For reads, d holds the bytes user logic supplies.
    task automatic run_txn(input string tag, input logic [7:0] ab, input int n,
                           input logic [3:0][7:0] d, input logic exp_ack, input int exp_rx);
        int         rx0, rd0, oe0;
        logic       ack_line;
        logic [7:0] b;
        logic       is_rd;
        is_rd = ab[0];
        rx0 = rx_cnt; rd0 = rd_cnt; oe0 = oe_cycles;
        if (is_rd)
            for (int i = 0; i < n; i++) tx_table[(rd0 + i) % 256] = d[i];
        i2c_start();
        write_byte(ab, ack_line);
        check({tag, " addr_ack"}, !ack_line, exp_ack);
        check({tag, " busy_after_addr"}, busy, exp_ack);
        for (int i = 0; i < n; i++) begin
            if (!is_rd) begin
                write_byte(d[i], ack_line);
                check({tag, " data_ack"}, !ack_line, exp_ack);
            end else begin
                read_byte(i == n - 1, b);
                check({tag, " read_byte"}, b, exp_ack ? d[i] : 8'hFF);
            end
        end
        check({tag, " busy_before_stop"}, busy, exp_ack && !is_rd);
        i2c_stop();
        tick(Q);
        check({tag, " busy_after_stop"}, busy, 0);
        check({tag, " rx_count"}, rx_cnt - rx0, exp_rx);
        for (int j = 0; j < exp_rx; j++)
            check({tag, " rx_byte"}, rx_log[(rx0 + j) % 64], d[j]);
        check({tag, " rd_req_count"}, rd_cnt - rd0, (is_rd && exp_ack) ? n : 0);
        if (!exp_ack)
            check({tag, " sda_oe_idle"}, oe_cycles - oe0, 0);
    endtask

    typedef struct {
        logic [7:0]      addr_byte;
        int              n;
        logic [3:0][7:0] data;      // data[0] goes first on the bus
        logic            exp_ack;
        int              exp_rx;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic       ack_line;
        logic       b;
        logic [7:0] v;
        logic [3:0] tail;
        int         rx0, rd0;
        logic [6:0] ra;
        logic       rrw;
        int         rn;
        logic [31:0] rd;
        logic       rm;

        vecs[0] = '{8'h84, 2, 32'h00003CA5, 1'b1, 2};
        vecs[1] = '{8'h85, 2, 32'h0000C35A, 1'b1, 0};
        vecs[2] = '{8'h90, 1, 32'h00000011, 1'b0, 0};
        vecs[3] = '{8'h00, 1, 32'h000000AA, 1'b0, 0};
        vecs[4] = '{8'h84, 3, 32'h00018000, 1'b1, 3};
        vecs[5] = '{8'h85, 3, 32'h00FF0100, 1'b1, 0};
        vecs[6] = '{8'h86, 1, 32'h00000055, 1'b0, 0};
        vecs[7] = '{8'h91, 2, 32'h00001234, 1'b0, 0};

        tick(6);
        reset = 1'b0;
        tick(2);
        check("rst sda_oe", sda_oe, 0);
        check("rst rx_data", rx_data, 8'h00);
        check("rst rx_valid", rx_valid, 0);
        check("rst rd_req", rd_req, 0);
        check("rst busy", busy, 0);

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].addr_byte, vecs[i].n,
                    vecs[i].data, vecs[i].exp_ack, vecs[i].exp_rx);

        // Repeated START: write 0x07, then Sr and read one byte
        rx0 = rx_cnt; rd0 = rd_cnt;
        tx_table[rd0 % 256] = 8'h96;
        i2c_start();
        write_byte(8'h84, ack_line); check("sr addr_w_ack", ack_line, 0);
        write_byte(8'h07, ack_line); check("sr data_ack", ack_line, 0);
        i2c_start();
        check("sr busy_cleared", busy, 0);
        write_byte(8'h85, ack_line); check("sr addr_r_ack", ack_line, 0);
        read_byte(1'b1, v);          check("sr read_byte", v, 8'h96);
        i2c_stop();
        tick(Q);
        check("sr rx_count", rx_cnt - rx0, 1);
        check("sr rx_byte", rx_log[rx0 % 64], 8'h07);
        check("sr rd_req_count", rd_cnt - rd0, 1);

        // Reset after 4 bits of a write data byte
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h84, ack_line); check("rstw addr_ack", ack_line, 0);
        for (int i = 7; i >= 4; i--) write_bit(v[i]);
        pulse_reset();
        for (int i = 3; i >= 0; i--) write_bit(v[i]);
        read_bit(ack_line); check("rstw no_ack", ack_line, 1);
        i2c_stop();
        tick(Q);
        check("rstw rx_count", rx_cnt - rx0, 0);
        run_txn("rstw_next", 8'h84, 1, 32'h000000C7, 1'b1, 1);

        // Reset while the target drives a read byte of zeros
        rd0 = rd_cnt;
        tx_table[rd0 % 256] = 8'h00;
        i2c_start();
        write_byte(8'h85, ack_line); check("rstr addr_ack", ack_line, 0);
        for (int i = 0; i < 4; i++) read_bit(b);
        check("rstr driving", sda_oe, 1);
        pulse_reset();
        tail = 4'h0;
        for (int i = 0; i < 4; i++) begin
            read_bit(b);
            tail = {tail[2:0], b};
        end
        check("rstr released_bits", tail, 4'hF);
        write_bit(1'b1);
        i2c_stop();
        run_txn("rstr_next", 8'h85, 1, 32'h0000003D, 1'b1, 0);

        // Early STOP after three data bits
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h84, ack_line); check("early addr_ack", ack_line, 0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        check("early busy_mid", busy, 1);
        i2c_stop();
        tick(Q);
        check("early busy_after", busy, 0);
        check("early rx_count", rx_cnt - rx0, 0);

        // Random transactions: the target answers only its own address;
        // matched writes are delivered in order, matched reads return the supplied bytes.
        for (int t = 0; t < 16; t++) begin
            ra  = ($urandom_range(0, 3) != 0) ? 7'h42 : 7'($urandom);
            rrw = 1'($urandom);
            rn  = $urandom_range(1, 3);
            rd  = $urandom;
            rm  = (ra == 7'h42);
            run_txn($sformatf("rnd%0d", t), {ra, rrw}, rn, rd, rm, (!rrw && rm) ? rn : 0);
        end

        check("protocol_rules", proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
